avalon_master_fsm: RTL and testbench
====================================

// Module: avalon_master_fsm
// PURPOSE
//  Avalon-MM bus master: turns simple local read/write enables into Avalon read/write cycles.
//  Sits between the Sobel datapath/controller and the SDRAM/on-chip memory Avalon slave.
//  Reads use a fixed slave latency; dataready flags the cycles in which readdata is valid.
// PARAMETERS
//  ADDR_W        32  address width (address, inaddr)
//  DATA_W        32  data width (readdata, writedata, wdata)
//  READ_LATENCY  3   clocks from read assertion until readdata valid; legal range 1..15
// PORTS
//  clk        in   1       system clock, rising edge
//  n_rst      in   1       asynchronous active-low reset
//  readen     in   1       local request: perform/hold a read of inaddr
//  writen     in   1       local request: perform/hold a write of wdata to inaddr
//  inaddr     in   ADDR_W  local address
//  wdata      in   DATA_W  local write data
//  readdata   in   DATA_W  Avalon read data from slave
//  read       out  1       Avalon read strobe
//  write      out  1       Avalon write strobe
//  address    out  ADDR_W  Avalon address (registered)
//  writedata  out  DATA_W  Avalon write data (registered)
//  dataready  out  1       readdata valid for the current read; local side samples readdata
// BEHAVIOUR
//  - One clock, clk; reset n_rst asynchronous active-low. All outputs are registered/state-decoded.
//  - Reset (any time, incl. mid-transfer): state=IDLE, read=0, write=0, dataready=0, address=0,
//    writedata=0, latency counter=0. Transfer in progress is abandoned.
//  - States: IDLE, RD_WAIT, RD_DONE, WR.
//  - IDLE: readen=1 -> RD_WAIT, latch address<=inaddr, counter<=1. Else writen=1 -> WR,
//    latch address<=inaddr, writedata<=wdata. readen has priority when both high.
//  - RD_WAIT: read=1, dataready=0. counter increments each clock; when counter==READ_LATENCY
//    -> RD_DONE. readen dropping -> IDLE (read aborted, no dataready).
//  - RD_DONE: read=1, dataready=1 (readdata passes through unmodified). Stays while readen=1.
//    readen=0 and writen=1 -> WR directly (latch inaddr/wdata); readen=0, writen=0 -> IDLE.
//  - WR: write=1, read=0, dataready=0; address/writedata re-latched from inaddr/wdata every clock
//    so a held writen tracks the local side. writen=0 -> IDLE (readen=1 -> RD_WAIT direct).
//  - read and write are never high together. writedata holds last written value outside WR.
//  - Read latency: dataready rises READ_LATENCY clocks after the edge that raised read.
// CONFIGURATION
//  AVALON_MASTER_WAITREQ_EN defined: adds input port waitrequest (1 bit, after readdata).
//   RD_WAIT counter and WR advance only when waitrequest=0; read/write, address, writedata held
//   stable while waitrequest=1. Undefined: no port, slave assumed never to stall.
// STRUCTURE
//  Package avalon_master_pkg: state enum typedef (IDLE/RD_WAIT/RD_DONE/WR), ADDR_W/DATA_W
//   default constants, latency counter width constant.
//  One sub-module: avalon_rd_latency_cnt (load/clear, enable, terminal-count flag at READ_LATENCY).
// TESTING
//  1. n_rst=0 for 3 clocks -> read=0, write=0, dataready=0, address=0, writedata=0.
//  2. Release reset, readen=1, inaddr=0, readdata=0; 2 clocks later -> read=1, write=0,
//     dataready=0, address=0.
//  3. Hold readen=1, readdata=5656; 2 more clocks -> read=1, dataready=1, address=0, write=0.
//  4. readen=0, writen=1, inaddr=6767, wdata=4444; 2 clocks -> write=1, read=0, dataready=0,
//     address=6767, writedata=4444.
//  5. readen=writen=1 from IDLE -> read path taken, write stays 0; drop readen in RD_WAIT
//     -> IDLE/WR with dataready never asserted.
//  6. Assert n_rst=0 in RD_DONE -> all outputs 0 immediately (before next clk edge).

Source files
------------

// File: rtl/avalon_master_pkg.sv
// Shared types and constants for the Avalon-MM master: FSM state encoding,
// default bus widths and the read-latency counter width.
package avalon_master_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_DONE = 2'd2,
      WR      = 2'd3
   } state_t;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   // Wide enough for the largest legal READ_LATENCY (15).
   localparam int CNT_W      = 4;

endpackage

// File: rtl/avalon_rd_latency_cnt.sv
// Read-latency counter: loads 1 when a read starts, counts while enabled, and
// flags terminal count once the slave's fixed read latency has elapsed.
module avalon_rd_latency_cnt
   import avalon_master_pkg::*;
#(
   parameter int READ_LATENCY = 3
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             load,
   input  logic             en,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count <= '0;
      end else if (load) begin
         count <= CNT_W'(1);
      end else if (en) begin
         count <= count + CNT_W'(1);
      end else if (clr) begin
         count <= '0;
      end
   end

   assign tc = (count == CNT_W'(READ_LATENCY));

endmodule

// File: rtl/avalon_master_fsm.sv
// Avalon-MM master FSM: converts local read/write enables into Avalon cycles.
// Optional slave stall support is enabled by defining AVALON_MASTER_WAITREQ_EN.
module avalon_master_fsm
   import avalon_master_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int READ_LATENCY = 3
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              readen,
   input  logic              writen,
   input  logic [ADDR_W-1:0] inaddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] readdata,
`ifdef AVALON_MASTER_WAITREQ_EN
   input  logic              waitrequest,
`endif
   output logic              read,
   output logic              write,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] writedata,
   output logic              dataready
);

   state_t           state;
   logic             stall;
   logic             tc;
   logic             cnt_load;
   logic             cnt_en;
   logic             cnt_clr;
   logic [CNT_W-1:0] count;

`ifdef AVALON_MASTER_WAITREQ_EN
   assign stall = waitrequest;
`else
   assign stall = 1'b0;
`endif

   // Counter is (re)loaded on every entry into RD_WAIT and parked at 0 elsewhere.
   always_comb begin
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      case (state)
         IDLE:    cnt_load = readen;
         RD_WAIT: cnt_en   = readen && !stall && !tc;
         WR:      cnt_load = !stall && !writen && readen;
         default: ;
      endcase
      cnt_clr = (state != RD_WAIT) && !cnt_load;
   end

   avalon_rd_latency_cnt #(
      .READ_LATENCY (READ_LATENCY)
   ) u_lat_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .load  (cnt_load),
      .en    (cnt_en),
      .clr   (cnt_clr),
      .count (count),
      .tc    (tc)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         read      <= 1'b0;
         write     <= 1'b0;
         dataready <= 1'b0;
         address   <= '0;
         writedata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (readen) begin
                  state   <= RD_WAIT;
                  read    <= 1'b1;
                  address <= inaddr;
               end else if (writen) begin
                  state     <= WR;
                  write     <= 1'b1;
                  address   <= inaddr;
                  writedata <= wdata;
               end
            end
            RD_WAIT: begin
               // A stalled slave must see read/address held, so nothing moves.
               if (!stall) begin
                  if (!readen) begin
                     state <= IDLE;
                     read  <= 1'b0;
                  end else if (tc) begin
                     state     <= RD_DONE;
                     dataready <= 1'b1;
                  end
               end
            end
            RD_DONE: begin
               if (!readen) begin
                  read      <= 1'b0;
                  dataready <= 1'b0;
                  if (writen) begin
                     state     <= WR;
                     write     <= 1'b1;
                     address   <= inaddr;
                     writedata <= wdata;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            WR: begin
               if (!stall) begin
                  if (writen) begin
                     address   <= inaddr;
                     writedata <= wdata;
                  end else begin
                     write <= 1'b0;
                     if (readen) begin
                        state   <= RD_WAIT;
                        read    <= 1'b1;
                        address <= inaddr;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
            end
            default: begin
               state     <= IDLE;
               read      <= 1'b0;
               write     <= 1'b0;
               dataready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_master_fsm.sv
// Directed bench for avalon_master_fsm: reset, read latency, writes, priority,
// aborted reads, direct state hops and asynchronous reset mid-transfer.
module tb_avalon_master_fsm;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        readen;
   logic        writen;
   logic [31:0] inaddr;
   logic [31:0] wdata;
   logic [31:0] readdata;
   logic        read;
   logic        write;
   logic [31:0] address;
   logic [31:0] writedata;
   logic        dataready;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   avalon_master_fsm #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .READ_LATENCY (3)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .readen      (readen),
      .writen      (writen),
      .inaddr      (inaddr),
      .wdata       (wdata),
      .readdata    (readdata),
`ifdef AVALON_MASTER_WAITREQ_EN
      .waitrequest (1'b0),
`endif
      .read        (read),
      .write       (write),
      .address     (address),
      .writedata   (writedata),
      .dataready   (dataready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0; readen = 1'b0; writen = 1'b0;
      inaddr = 32'd0; wdata = 32'd0; readdata = 32'd0;
      repeat (3) tick();
      n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL rst_read got %0b exp 0", read); end
      n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL rst_write got %0b exp 0", write); end
      n_cmp++; if (dataready !== 1'b0) begin n_bad++; $display("FAIL rst_dataready got %0b exp 0", dataready); end
      n_cmp++; if (address !== 32'd0) begin n_bad++; $display("FAIL rst_address got %0d exp 0", address); end
      n_cmp++; if (writedata !== 32'd0) begin n_bad++; $display("FAIL rst_writedata got %0d exp 0", writedata); end
   endtask

   task automatic test_read();
      n_rst = 1'b1; readen = 1'b1; inaddr = 32'd0; readdata = 32'd0;
      tick(); tick();
      n_cmp++; if (read !== 1'b1) begin n_bad++; $display("FAIL rd_wait_read got %0b exp 1", read); end
      n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL rd_wait_write got %0b exp 0", write); end
      n_cmp++; if (dataready !== 1'b0) begin n_bad++; $display("FAIL rd_wait_dataready got %0b exp 0", dataready); end
      n_cmp++; if (address !== 32'd0) begin n_bad++; $display("FAIL rd_wait_address got %0d exp 0", address); end
      readdata = 32'd5656;
      tick(); tick();
      n_cmp++; if (read !== 1'b1) begin n_bad++; $display("FAIL rd_done_read got %0b exp 1", read); end
      n_cmp++; if (dataready !== 1'b1) begin n_bad++; $display("FAIL rd_done_dataready got %0b exp 1", dataready); end
      n_cmp++; if (address !== 32'd0) begin n_bad++; $display("FAIL rd_done_address got %0d exp 0", address); end
      n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL rd_done_write got %0b exp 0", write); end
   endtask

   task automatic test_write();
      // Starts in RD_DONE: hops straight to WR.
      readen = 1'b0; writen = 1'b1; inaddr = 32'd6767; wdata = 32'd4444;
      tick(); tick();
      n_cmp++; if (write !== 1'b1) begin n_bad++; $display("FAIL wr_write got %0b exp 1", write); end
      n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL wr_read got %0b exp 0", read); end
      n_cmp++; if (dataready !== 1'b0) begin n_bad++; $display("FAIL wr_dataready got %0b exp 0", dataready); end
      n_cmp++; if (address !== 32'd6767) begin n_bad++; $display("FAIL wr_address got %0d exp 6767", address); end
      n_cmp++; if (writedata !== 32'd4444) begin n_bad++; $display("FAIL wr_writedata got %0d exp 4444", writedata); end
      inaddr = 32'd100; wdata = 32'd200;
      tick();
      n_cmp++; if (address !== 32'd100) begin n_bad++; $display("FAIL wr_track_address got %0d exp 100", address); end
      n_cmp++; if (writedata !== 32'd200) begin n_bad++; $display("FAIL wr_track_writedata got %0d exp 200", writedata); end
      writen = 1'b0; wdata = 32'd999;
      tick();
      n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL wr_end_write got %0b exp 0", write); end
      n_cmp++; if (writedata !== 32'd200) begin n_bad++; $display("FAIL wr_hold_writedata got %0d exp 200", writedata); end
   endtask

   task automatic test_priority();
      readen = 1'b1; writen = 1'b1; inaddr = 32'h55; wdata = 32'h99;
      tick();
      n_cmp++; if (read !== 1'b1) begin n_bad++; $display("FAIL pri_read got %0b exp 1", read); end
      n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL pri_write got %0b exp 0", write); end
      n_cmp++; if (address !== 32'h55) begin n_bad++; $display("FAIL pri_address got %0h exp 55", address); end
      n_cmp++; if (writedata !== 32'd200) begin n_bad++; $display("FAIL pri_writedata got %0d exp 200", writedata); end
      tick();
      n_cmp++; if (dataready !== 1'b0) begin n_bad++; $display("FAIL abort_pre_dataready got %0b exp 0", dataready); end
      readen = 1'b0;
      tick();
      n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL abort_read got %0b exp 0", read); end
      n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL abort_write got %0b exp 0", write); end
      n_cmp++; if (dataready !== 1'b0) begin n_bad++; $display("FAIL abort_dataready got %0b exp 0", dataready); end
      tick();
      n_cmp++; if (write !== 1'b1) begin n_bad++; $display("FAIL abort_to_wr_write got %0b exp 1", write); end
      n_cmp++; if (dataready !== 1'b0) begin n_bad++; $display("FAIL abort_to_wr_dataready got %0b exp 0", dataready); end
      n_cmp++; if (writedata !== 32'h99) begin n_bad++; $display("FAIL abort_to_wr_writedata got %0h exp 99", writedata); end
   endtask

   task automatic test_back_to_back();
      // WR with writen dropped and readen raised goes straight to RD_WAIT.
      writen = 1'b0; readen = 1'b1; inaddr = 32'h77;
      tick();
      n_cmp++; if (read !== 1'b1) begin n_bad++; $display("FAIL b2b_read got %0b exp 1", read); end
      n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL b2b_write got %0b exp 0", write); end
      n_cmp++; if (address !== 32'h77) begin n_bad++; $display("FAIL b2b_address got %0h exp 77", address); end
      readen = 1'b0;
      tick();
      n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_read got %0b exp 0", read); end
   endtask

   task automatic test_latency();
      readen = 1'b1; inaddr = 32'hABCD;
      tick();
      n_cmp++; if (read !== 1'b1) begin n_bad++; $display("FAIL lat_e0_read got %0b exp 1", read); end
      n_cmp++; if (dataready !== 1'b0) begin n_bad++; $display("FAIL lat_e0_dataready got %0b exp 0", dataready); end
      tick();
      n_cmp++; if (dataready !== 1'b0) begin n_bad++; $display("FAIL lat_e1_dataready got %0b exp 0", dataready); end
      tick();
      n_cmp++; if (dataready !== 1'b0) begin n_bad++; $display("FAIL lat_e2_dataready got %0b exp 0", dataready); end
      tick();
      n_cmp++; if (dataready !== 1'b1) begin n_bad++; $display("FAIL lat_e3_dataready got %0b exp 1", dataready); end
      n_cmp++; if (address !== 32'hABCD) begin n_bad++; $display("FAIL lat_address got %0h exp abcd", address); end
      tick();
      n_cmp++; if (dataready !== 1'b1) begin n_bad++; $display("FAIL lat_hold_dataready got %0b exp 1", dataready); end
   endtask

   task automatic test_async_reset();
      // Still in RD_DONE with readen held; reset lands between clock edges.
      #2 n_rst = 1'b0;
      #1;
      n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL arst_read got %0b exp 0", read); end
      n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL arst_write got %0b exp 0", write); end
      n_cmp++; if (dataready !== 1'b0) begin n_bad++; $display("FAIL arst_dataready got %0b exp 0", dataready); end
      n_cmp++; if (address !== 32'd0) begin n_bad++; $display("FAIL arst_address got %0h exp 0", address); end
      n_cmp++; if (writedata !== 32'd0) begin n_bad++; $display("FAIL arst_writedata got %0h exp 0", writedata); end
      tick();
      readen = 1'b0; n_rst = 1'b1;
      tick();
      n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL arst_post_read got %0b exp 0", read); end
      n_cmp++; if (dataready !== 1'b0) begin n_bad++; $display("FAIL arst_post_dataready got %0b exp 0", dataready); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_priority();
      test_back_to_back();
      test_latency();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
